// File: rtl/video_wb_arbiter.sv
// video_wb_arbiter: shares one Wishbone master port to RAM between the frame
// writer (m0) and the frame reader (m1). Round-robin ownership with a burst
// limit, LOCK honouring and an ACK watchdog that aborts stalled transfers.
module video_wb_arbiter #(
    parameter int MAX_BURST = 16,   // ACKed transfers per grant before handover
    parameter int TIMEOUT   = 255   // STB cycles allowed without ACK/ERR (1..255)
) (
    input  logic        clk,
    input  logic        RST,

    input  logic        m0_wb_CYC_I,
    input  logic        m0_wb_STB_I,
    input  logic        m0_wb_LOCK_I,
    input  logic        m0_wb_WE_I,
    input  logic [3:0]  m0_wb_SEL_I,
    input  logic [31:0] m0_wb_ADR_I,
    input  logic [31:0] m0_wb_DAT_I,
    output logic        m0_wb_ACK_O,
    output logic        m0_wb_ERR_O,
    output logic [31:0] m0_wb_DAT_O,

    input  logic        m1_wb_CYC_I,
    input  logic        m1_wb_STB_I,
    input  logic        m1_wb_LOCK_I,
    input  logic        m1_wb_WE_I,
    input  logic [3:0]  m1_wb_SEL_I,
    input  logic [31:0] m1_wb_ADR_I,
    input  logic [31:0] m1_wb_DAT_I,
    output logic        m1_wb_ACK_O,
    output logic        m1_wb_ERR_O,
    output logic [31:0] m1_wb_DAT_O,

    output logic        s_wb_CYC_O,
    output logic        s_wb_STB_O,
    output logic        s_wb_LOCK_O,
    output logic        s_wb_WE_O,
    output logic [3:0]  s_wb_SEL_O,
    output logic [31:0] s_wb_ADR_O,
    output logic [31:0] s_wb_DAT_O,
    input  logic        s_wb_ACK_I,
    input  logic        s_wb_ERR_I,
    input  logic [31:0] s_wb_DAT_I,

    output logic [1:0]  grant,
    output logic        timeout_err
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_BURST);
    localparam logic [7:0]    WD_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, OWN0, OWN1, GAP} state_t;

    state_t        state_reg, state_next;
    logic          last_reg, last_next;          // 0 = m0 owned last, 1 = m1
    logic [BW-1:0] burst_cnt_reg, burst_cnt_next;
    logic [7:0]    wd_cnt_reg, wd_cnt_next;

    logic own_active;
    logic own_cyc, own_stb, own_lock, other_cyc;
    logic burst_full;
    logic wd_fire;
    logic [1:0] ack_vec, err_vec;

    assign own_active = (state_reg == OWN0) || (state_reg == OWN1);
    assign burst_full = (burst_cnt_reg == BURST_MAX);

    // Select the current owner's request lines and the competitor's CYC.
    always_comb begin
        own_cyc   = m0_wb_CYC_I;
        own_stb   = m0_wb_STB_I;
        own_lock  = m0_wb_LOCK_I;
        other_cyc = m1_wb_CYC_I;
        if (state_reg == OWN1) begin
            own_cyc   = m1_wb_CYC_I;
            own_stb   = m1_wb_STB_I;
            own_lock  = m1_wb_LOCK_I;
            other_cyc = m0_wb_CYC_I;
        end
    end

    // A response from the slave in the final watchdog cycle beats the abort.
    assign wd_fire = own_active && own_stb && (wd_cnt_reg == WD_LAST)
                     && !s_wb_ACK_I && !s_wb_ERR_I;

    // Register state, round-robin history, burst and watchdog counters.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            burst_cnt_reg <= '0;
            wd_cnt_reg    <= '0;
        end else begin
            state_reg     <= state_next;
            last_reg      <= last_next;
            burst_cnt_reg <= burst_cnt_next;
            wd_cnt_reg    <= wd_cnt_next;
        end
    end

    // Arbitration, handover conditions and counter updates.
    always_comb begin
        state_next     = state_reg;
        last_next      = last_reg;
        burst_cnt_next = burst_cnt_reg;
        wd_cnt_next    = wd_cnt_reg;
        case (state_reg)
            OWN0, OWN1: begin
                // The burst limit uses the registered count, so it only
                // takes effect in the cycle after the limiting ACK.
                if (!own_cyc || (burst_full && other_cyc && !own_lock) || wd_fire) begin
                    state_next     = GAP;
                    burst_cnt_next = '0;
                    wd_cnt_next    = '0;
                end else begin
                    if (s_wb_ACK_I && !burst_full) begin
                        burst_cnt_next = burst_cnt_reg + BW'(1);
                    end
                    if (s_wb_ACK_I || s_wb_ERR_I) begin
                        wd_cnt_next = '0;
                    end else if (own_stb) begin
                        wd_cnt_next = wd_cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; GAP only lasts one cycle
                // because every path out of it leaves the state.
                state_next     = IDLE;
                burst_cnt_next = '0;
                wd_cnt_next    = '0;
                if (m0_wb_CYC_I && m1_wb_CYC_I) begin
                    state_next = last_reg ? OWN0 : OWN1;
                    last_next  = ~last_reg;
                end else if (m0_wb_CYC_I) begin
                    state_next = OWN0;
                    last_next  = 1'b0;
                end else if (m1_wb_CYC_I) begin
                    state_next = OWN1;
                    last_next  = 1'b1;
                end
            end
        endcase
    end

    // Route the owner's bus to the slave; nothing is driven without an owner.
    always_comb begin
        s_wb_CYC_O  = 1'b0;
        s_wb_STB_O  = 1'b0;
        s_wb_LOCK_O = 1'b0;
        s_wb_WE_O   = 1'b0;
        s_wb_SEL_O  = '0;
        s_wb_ADR_O  = '0;
        s_wb_DAT_O  = '0;
        case (state_reg)
            OWN0: begin
                s_wb_CYC_O  = m0_wb_CYC_I;
                s_wb_STB_O  = m0_wb_STB_I;
                s_wb_LOCK_O = m0_wb_LOCK_I;
                s_wb_WE_O   = m0_wb_WE_I;
                s_wb_SEL_O  = m0_wb_SEL_I;
                s_wb_ADR_O  = m0_wb_ADR_I;
                s_wb_DAT_O  = m0_wb_DAT_I;
            end
            OWN1: begin
                s_wb_CYC_O  = m1_wb_CYC_I;
                s_wb_STB_O  = m1_wb_STB_I;
                s_wb_LOCK_O = m1_wb_LOCK_I;
                s_wb_WE_O   = m1_wb_WE_I;
                s_wb_SEL_O  = m1_wb_SEL_I;
                s_wb_ADR_O  = m1_wb_ADR_I;
                s_wb_DAT_O  = m1_wb_DAT_I;
            end
            default: ;
        endcase
    end

    assign grant       = {state_reg == OWN1, state_reg == OWN0};
    assign timeout_err = wd_fire;

    // Responses only reach the master that currently owns the bus.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign ack_vec[gi] = grant[gi] & s_wb_ACK_I;
            assign err_vec[gi] = grant[gi] & (s_wb_ERR_I | wd_fire);
        end
    endgenerate

    assign m0_wb_ACK_O = ack_vec[0];
    assign m0_wb_ERR_O = err_vec[0];
    assign m1_wb_ACK_O = ack_vec[1];
    assign m1_wb_ERR_O = err_vec[1];
    assign m0_wb_DAT_O = s_wb_DAT_I;
    assign m1_wb_DAT_O = s_wb_DAT_I;

endmodule
